// File: rtl/aqed_multi_pair_checker_if.sv
// Stimulus/core-side bundle for the A-QED multi-pair checker.
// The checker takes the slave side; stimulus plus core model take the master side.
interface aqed_multi_pair_checker_if #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_PAIRS  = 4
);
    logic                               clk_en;
    logic                               flush;
    logic                               exec_dup;
    logic                               wen_in;
    logic                               ren_in;
    logic                               full;
    logic                               empty;
    logic                               valid_out;
    logic [DATA_WIDTH-1:0]              data_in;
    logic [DATA_WIDTH-1:0]              data_out_in;
    logic [DATA_WIDTH-1:0]              data_out;
    logic                               qed_done;
    logic                               qed_check;
    logic                               qed_fail;
    logic                               qed_timeout;
    logic [$clog2(NUM_PAIRS+1)-1:0]     pairs_done;

    modport slave (
        input  clk_en, flush, exec_dup, wen_in, ren_in, full, empty, valid_out,
               data_in, data_out_in,
        output data_out, qed_done, qed_check, qed_fail, qed_timeout, pairs_done
    );

    modport master (
        output clk_en, flush, exec_dup, wen_in, ren_in, full, empty, valid_out,
               data_in, data_out_in,
        input  data_out, qed_done, qed_check, qed_fail, qed_timeout, pairs_done
    );
endinterface

// File: rtl/aqed_multi_pair_checker.sv
// A-QED self-consistency checker: tracks up to NUM_PAIRS orig/dup write pairs
// through a memory core and flags any pair whose two read-outs differ.
module aqed_multi_pair_checker #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_PAIRS  = 4,
    parameter int CNT_WIDTH  = 32,
    parameter int TIMEOUT    = 1024
) (
    input  logic                         clk,
    input  logic                         reset,
    aqed_multi_pair_checker_if.slave     bus
);
    localparam int PW = $clog2(NUM_PAIRS + 1);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] T_LAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;
    localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT);

    typedef enum logic [1:0] {S_FREE, S_ORIG, S_DUP, S_CMP} slot_st_e;

    slot_st_e st     [NUM_PAIRS];
    slot_st_e st_nxt [NUM_PAIRS];

    logic [NUM_PAIRS-1:0][DATA_WIDTH-1:0] slot_data, orig_out, dup_out;
    logic [NUM_PAIRS-1:0][CNT_WIDTH-1:0]  orig_idx, dup_idx;
    logic [NUM_PAIRS-1:0]                 got_orig, got_dup;
    logic [NUM_PAIRS-1:0]                 free_oh, orig_oh, cmp_hit, mismatch;

    logic [CNT_WIDTH-1:0] in_count, out_count;
    logic [TW-1:0]        tcnt;
    logic [PW-1:0]        pairs_done, n_cmp, pd_nxt;
    logic                 qed_done, qed_check, qed_fail, qed_timeout;

    logic                  any_orig, any_dup, free_found;
    logic [DATA_WIDTH-1:0] orig_data;
    logic                  accept, orig_issue, dup_issue, rd_cap, flush_en;

    // Slot scan: lowest FREE slot wins allocation; at most one slot is ORIG.
    always_comb begin
        any_orig   = 1'b0;
        any_dup    = 1'b0;
        free_found = 1'b0;
        free_oh    = '0;
        orig_oh    = '0;
        orig_data  = '0;
        for (int i = 0; i < NUM_PAIRS; i++) begin
            if (st[i] == S_ORIG) begin
                any_orig   = 1'b1;
                orig_oh[i] = 1'b1;
                orig_data  = orig_data | slot_data[i];
            end
            if (st[i] == S_DUP) any_dup = 1'b1;
            if (st[i] == S_FREE && !free_found) begin
                free_oh[i] = 1'b1;
                free_found = 1'b1;
            end
        end
    end

    assign flush_en   = bus.clk_en & bus.flush;
    assign accept     = ~reset & bus.clk_en & bus.wen_in & ~bus.flush & (~bus.full | bus.ren_in);
    assign orig_issue = accept & bus.exec_dup & ~any_orig & free_found;
    assign dup_issue  = accept & bus.exec_dup & any_orig;
    assign rd_cap     = bus.clk_en & bus.valid_out & ~bus.empty & ~bus.flush;

    assign bus.data_out = dup_issue ? orig_data : bus.data_in;

    always_comb begin
        n_cmp    = '0;
        cmp_hit  = '0;
        mismatch = '0;
        for (int i = 0; i < NUM_PAIRS; i++) begin
            cmp_hit[i]  = bus.clk_en & ~bus.flush & (st[i] == S_DUP) & got_orig[i] & got_dup[i];
            mismatch[i] = cmp_hit[i] & (orig_out[i] != dup_out[i]);
            n_cmp       = n_cmp + PW'(cmp_hit[i]);
        end
        pd_nxt = pairs_done + n_cmp;
    end

    always_comb begin
        for (int i = 0; i < NUM_PAIRS; i++) begin
            st_nxt[i] = st[i];
            if (bus.clk_en) begin
                if (bus.flush && (st[i] == S_ORIG || st[i] == S_DUP)) st_nxt[i] = S_FREE;
                else if (orig_issue && free_oh[i])                   st_nxt[i] = S_ORIG;
                else if (dup_issue && orig_oh[i])                    st_nxt[i] = S_DUP;
                else if (cmp_hit[i])                                 st_nxt[i] = S_CMP;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_PAIRS; i++) st[i] <= S_FREE;
            slot_data   <= '0;
            orig_out    <= '0;
            dup_out     <= '0;
            orig_idx    <= '0;
            dup_idx     <= '0;
            got_orig    <= '0;
            got_dup     <= '0;
            in_count    <= '0;
            out_count   <= '0;
            tcnt        <= '0;
            pairs_done  <= '0;
            qed_done    <= 1'b0;
            qed_check   <= 1'b1;
            qed_fail    <= 1'b0;
            qed_timeout <= 1'b0;
        end else if (bus.clk_en) begin
            for (int i = 0; i < NUM_PAIRS; i++) st[i] <= st_nxt[i];

            if (flush_en) begin
                in_count  <= '0;
                out_count <= '0;
                tcnt      <= '0;
            end else begin
                if (accept) in_count  <= in_count + CNT_WIDTH'(1);
                if (rd_cap) out_count <= out_count + CNT_WIDTH'(1);
                // Liveness: count while any dup is awaiting its outputs.
                if (any_dup) begin
                    if (tcnt != T_MAX) tcnt <= tcnt + TW'(1);
                    if (TIMEOUT > 0 && tcnt == T_LAST) qed_timeout <= 1'b1;
                end else begin
                    tcnt <= '0;
                end
            end

            for (int i = 0; i < NUM_PAIRS; i++) begin
                if (orig_issue && free_oh[i]) begin
                    slot_data[i] <= bus.data_in;
                    orig_idx[i]  <= in_count;
                    got_orig[i]  <= 1'b0;
                    got_dup[i]   <= 1'b0;
                end
                if (dup_issue && orig_oh[i]) dup_idx[i] <= in_count;
                // dup_idx is stale until the slot reaches DUP, so only match it there.
                if (rd_cap) begin
                    if ((st[i] == S_ORIG || st[i] == S_DUP) && orig_idx[i] == out_count) begin
                        orig_out[i] <= bus.data_out_in;
                        got_orig[i] <= 1'b1;
                    end
                    if (st[i] == S_DUP && dup_idx[i] == out_count) begin
                        dup_out[i] <= bus.data_out_in;
                        got_dup[i] <= 1'b1;
                    end
                end
            end

            pairs_done <= pd_nxt;
            qed_done   <= (pd_nxt != '0);
            if (|mismatch) begin
                qed_fail  <= 1'b1;
                qed_check <= 1'b0;
            end
        end
    end

    assign bus.qed_done    = qed_done;
    assign bus.qed_check   = qed_check;
    assign bus.qed_fail    = qed_fail;
    assign bus.qed_timeout = qed_timeout;
    assign bus.pairs_done  = pairs_done;
endmodule

// File: tb/tb_aqed_multi_pair_checker.sv
// Directed bench for aqed_multi_pair_checker (NUM_PAIRS=4, TIMEOUT=8).
module tb_aqed_multi_pair_checker;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    aqed_multi_pair_checker_if #(.DATA_WIDTH(16), .NUM_PAIRS(4)) bus ();

    aqed_multi_pair_checker #(
        .DATA_WIDTH(16), .NUM_PAIRS(4), .CNT_WIDTH(32), .TIMEOUT(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.clk_en      = 1'b1;
        bus.flush       = 1'b0;
        bus.exec_dup    = 1'b0;
        bus.wen_in      = 1'b0;
        bus.ren_in      = 1'b0;
        bus.full        = 1'b0;
        bus.empty       = 1'b1;
        bus.valid_out   = 1'b0;
        bus.data_in     = '0;
        bus.data_out_in = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic wr(input logic [15:0] d, input logic dup);
        bus.wen_in   = 1'b1;
        bus.exec_dup = dup;
        bus.data_in  = d;
        cyc();
        bus.wen_in   = 1'b0;
        bus.exec_dup = 1'b0;
    endtask

    // exec_dup write that also checks the combinational data_out this cycle.
    task automatic wr_chk(input string tag, input logic [15:0] d, input logic [15:0] exp_out);
        bus.wen_in   = 1'b1;
        bus.exec_dup = 1'b1;
        bus.data_in  = d;
        #1;
        chk(tag, 32'(bus.data_out), 32'(exp_out));
        cyc();
        bus.wen_in   = 1'b0;
        bus.exec_dup = 1'b0;
    endtask

    task automatic rd(input logic [15:0] d);
        bus.valid_out   = 1'b1;
        bus.empty       = 1'b0;
        bus.data_out_in = d;
        cyc();
        bus.valid_out   = 1'b0;
        bus.empty       = 1'b1;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        bus.data_in = 16'h5A5A;
        #3;
        chk("rst_data_out", 32'(bus.data_out), 32'h5A5A);
        chk("rst_done", 32'(bus.qed_done), 0);
        chk("rst_check", 32'(bus.qed_check), 1);
        chk("rst_fail", 32'(bus.qed_fail), 0);
        chk("rst_timeout", 32'(bus.qed_timeout), 0);
        chk("rst_pairs", 32'(bus.pairs_done), 0);
        do_reset();

        // Basic pair: orig idx 0, dup idx 4.
        wr(16'h00A5, 1'b1);
        wr(16'h0001, 1'b0);
        wr(16'h0002, 1'b0);
        wr(16'h0003, 1'b0);
        wr_chk("basic_dup_data_out", 16'h1234, 16'h00A5);
        rd(16'h00A5); rd(16'h0001); rd(16'h0002); rd(16'h0003); rd(16'h00A5);
        chk("basic_done_not_yet", 32'(bus.qed_done), 0);
        cyc();
        chk("basic_done", 32'(bus.qed_done), 1);
        chk("basic_check", 32'(bus.qed_check), 1);
        chk("basic_pairs", 32'(bus.pairs_done), 1);
        chk("basic_fail", 32'(bus.qed_fail), 0);
        chk("basic_timeout", 32'(bus.qed_timeout), 0);

        // Mismatch: orig idx 5, dup idx 9, dup read returns A4.
        wr(16'h00A5, 1'b1);
        wr(16'h0001, 1'b0);
        wr(16'h0002, 1'b0);
        wr(16'h0003, 1'b0);
        wr_chk("mm_dup_data_out", 16'h1234, 16'h00A5);
        rd(16'h00A5); rd(16'h0001); rd(16'h0002); rd(16'h0003); rd(16'h00A4);
        cyc();
        chk("mm_fail", 32'(bus.qed_fail), 1);
        chk("mm_check", 32'(bus.qed_check), 0);
        chk("mm_pairs", 32'(bus.pairs_done), 2);
        bus.flush = 1'b1;
        cyc();
        bus.flush = 1'b0;
        chk("mm_fail_after_flush", 32'(bus.qed_fail), 1);
        wr(16'h0042, 1'b1);
        wr_chk("mm_good_dup", 16'h0043, 16'h0042);
        rd(16'h0042); rd(16'h0042);
        cyc();
        chk("mm_good_pairs", 32'(bus.pairs_done), 3);
        chk("mm_fail_sticky", 32'(bus.qed_fail), 1);
        chk("mm_check_sticky", 32'(bus.qed_check), 0);

        // Full backpressure: blocked write must not allocate or count.
        do_reset();
        bus.full = 1'b1;
        bus.wen_in = 1'b1; bus.exec_dup = 1'b1; bus.data_in = 16'h0BEE;
        #1;
        chk("bp_blocked_data_out", 32'(bus.data_out), 32'h0BEE);
        cyc();
        bus.ren_in = 1'b1;
        wr(16'h0C01, 1'b1);
        bus.full = 1'b0; bus.ren_in = 1'b0;
        wr_chk("bp_dup_data_out", 16'h0C02, 16'h0C01);
        rd(16'h0C01); rd(16'h0C01);
        cyc();
        chk("bp_pairs", 32'(bus.pairs_done), 1);
        chk("bp_check", 32'(bus.qed_check), 1);

        // Slot exhaustion: four pairs, then a fifth exec_dup write is ordinary.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wr(16'h0100 + 16'(i), 1'b1);
            wr(16'h0F00, 1'b1);
        end
        wr_chk("ex_fifth_ordinary", 16'h0055, 16'h0055);
        for (int i = 0; i < 4; i++) begin
            rd(16'h0100 + 16'(i));
            rd(16'h0100 + 16'(i));
        end
        rd(16'h0055);
        cyc();
        chk("ex_pairs", 32'(bus.pairs_done), 4);
        chk("ex_check", 32'(bus.qed_check), 1);
        chk("ex_fail", 32'(bus.qed_fail), 0);

        // Flush mid-pair: slot freed, counters zeroed, write in flush cycle dropped.
        do_reset();
        wr(16'h0111, 1'b1);
        bus.flush = 1'b1;
        wr(16'h0999, 1'b1);
        bus.flush = 1'b0;
        wr_chk("fl_new_orig", 16'h0222, 16'h0222);
        wr_chk("fl_new_dup", 16'h0333, 16'h0222);
        rd(16'h0222); rd(16'h0222);
        cyc();
        chk("fl_pairs", 32'(bus.pairs_done), 1);
        chk("fl_fail", 32'(bus.qed_fail), 0);
        chk("fl_check", 32'(bus.qed_check), 1);

        // Timeout: 7 enabled cycles, 3 frozen, then the 8th trips it.
        do_reset();
        wr(16'h0777, 1'b1);
        wr(16'h0778, 1'b1);
        repeat (7) cyc();
        chk("to_before", 32'(bus.qed_timeout), 0);
        bus.clk_en = 1'b0;
        repeat (3) cyc();
        chk("to_frozen", 32'(bus.qed_timeout), 0);
        bus.clk_en = 1'b1;
        cyc();
        chk("to_set", 32'(bus.qed_timeout), 1);
        cyc();
        chk("to_sticky", 32'(bus.qed_timeout), 1);

        // Asynchronous reset clears sticky state without a clock edge.
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("arst_timeout", 32'(bus.qed_timeout), 0);
        chk("arst_check", 32'(bus.qed_check), 1);
        reset = 1'b0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/aqed_multi_pair_checker.md
Name: aqed_multi_pair_checker

Overview:
- Parametrised A-QED self-consistency checker for a memory core (FIFO / line-buffer) under formal or simulation verification.
- Sits between the stimulus and the core:
  - muxes the write data into the core;
  - records up to NUM_PAIRS original/duplicate write pairs;
  - captures the core's read-out data for each pair and flags any pair whose duplicate output differs from its original.
- Generalises the single-pair checker: configurable width and pair count, flush-safe slot tracking, sticky failure and a liveness timeout.

Parameters:
- DATA_WIDTH, 16, width of write/read data.
- NUM_PAIRS, 4, number of orig/dup pair slots (1..16).
- CNT_WIDTH, 32, width of write/read sequence counters.
- TIMEOUT, 1024, clk_en cycles allowed from dup issue to both outputs captured; 0 disables the timeout.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- clk_en  in  1  qualifies all state updates
- flush  in  1  synchronous core flush; clears in-flight tracking
- exec_dup  in  1  request to start or complete a pair on the next accepted write
- wen_in  in  1  write request to core
- ren_in  in  1  read request to core
- full  in  1  core full
- empty  in  1  core empty
- valid_out  in  1  core read data valid
- data_in  in  DATA_WIDTH  stimulus write data
- data_out_in  in  DATA_WIDTH  core read data
- data_out  out  DATA_WIDTH  write data driven to core
- qed_done  out  1  at least one pair fully compared
- qed_check  out  1  all compared pairs matched (1 when none compared)
- qed_fail  out  1  sticky mismatch
- qed_timeout  out  1  sticky liveness violation
- pairs_done  out  $clog2(NUM_PAIRS+1)  count of compared pairs

Behaviour:
- Reset (async): all slots FREE, in_count = out_count = 0, pending = none, timeout counter 0. Outputs: data_out = data_in (combinational), qed_done = 0, qed_check = 1, qed_fail = 0, qed_timeout = 0, pairs_done = 0.
- accept = ~reset & clk_en & wen_in & ~flush & (~full | ren_in).
- Each accepted write increments in_count (wraps modulo 2^CNT_WIDTH).
- Slot states: FREE -> ORIG (orig issued) -> DUP (dup issued, outputs outstanding) -> CMP (compared). Slots are allocated lowest-index-FREE first.
- Orig issue:
  - Condition: accept & exec_dup & no slot in ORIG & a FREE slot exists.
  - Slot stores data_in, orig_idx = in_count; state -> ORIG.
  - With no FREE slot, exec_dup is ignored and the write is ordinary.
- Dup issue:
  - Condition: accept & exec_dup & a slot in ORIG.
  - data_out = that slot's stored data (combinational, same cycle); slot stores dup_idx = in_count; state -> DUP.
- Concurrency: at most one slot is in ORIG at any time, but any number of slots may be in DUP concurrently.
- Read capture:
  - Trigger: clk_en & valid_out & ~empty & ~flush. Increments out_count.
  - Any slot whose orig_idx or dup_idx equals out_count captures data_out_in into orig_out or dup_out and sets got_orig or got_dup.
  - Indices are compared only in states ORIG/DUP.
- Compare:
  - Trigger: a slot in DUP with got_orig & got_dup. The compare happens the cycle after the second capture.
  - Slot -> CMP; pairs_done++.
  - If orig_out != dup_out: qed_fail <= 1 and qed_check <= 0 (both sticky).
  - qed_done = (pairs_done != 0), registered.
- Timeout:
  - Counter increments per clk_en cycle while any slot is in DUP.
  - Counter resets to 0 when no slot is in DUP.
  - Reaching TIMEOUT sets qed_timeout (sticky).
- Flush (sync, clk_en-qualified):
  - in_count, out_count and the timeout counter <= 0; slots in ORIG/DUP -> FREE.
  - CMP slots, pairs_done, qed_fail, qed_timeout and qed_check are retained.
  - A write in the flush cycle is not accepted.
- clk_en low: no state changes; data_out remains combinational.
- Reset mid-operation: the asynchronous assert clears everything immediately, including the sticky flags.
- Wrap: an index match uses the full CNT_WIDTH equality. Pairs with orig/dup separated by ≥2^CNT_WIDTH writes are unsupported (document as an assumption in the formal environment).

Test Plan:
- Basic pair: reset, then write 0x00A5 with exec_dup, 3 plain writes, 1 write with exec_dup (data_in = 0x1234), then read 5 words returning 0x00A5,x,x,x,0x00A5 -> data_out = 0x00A5 on the dup cycle; qed_done = 1 one cycle after the 5th read; qed_check = 1; pairs_done = 1.
- Mismatch: same sequence with the 5th read returning 0x00A4 -> qed_fail = 1, qed_check = 0; both stay set after flush and further good pairs.
- Full backpressure: full = 1, ren_in = 0, wen_in = 1, exec_dup = 1 -> no issue, in_count unchanged. Then full = 1, ren_in = 1 -> orig issued.
- Slot exhaustion: NUM_PAIRS = 4; issue 4 pairs, then a 5th exec_dup write -> treated as ordinary (in_count +1, no slot change). Read all outputs correctly -> pairs_done = 4, qed_check = 1.
- Flush mid-pair: orig issued, then flush -> slot FREE, counters 0. A new pair after the flush completes -> pairs_done = 1, no false fail.
- Timeout: TIMEOUT = 8; dup issued, valid_out held 0 for 8 clk_en cycles -> qed_timeout = 1 on the 8th cycle. With clk_en = 0 the counter is frozen.
